// File: rtl/seg7_scan_mux_pkg.sv
// seg7_scan_mux_pkg: shared constants plus onehot(idx) and lead_blank_mask(act, n) helpers for scanned displays
package seg7_scan_mux_pkg;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_TICK_DIV = 50000;
  localparam int MAX_DIGITS = 8;
  localparam int MAX_BITS = 4 * MAX_DIGITS;
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction
  function automatic logic [MAX_DIGITS-1:0] lead_blank_mask(input logic [MAX_BITS-1:0] act, input int n);
    logic [MAX_DIGITS-1:0] m;
    logic z;
    m = '0;
    z = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < n) begin
        z = z & (act[4*i +: 4] == 4'h0);
        m[i] = z;
      end
    end
    return m;
  endfunction
endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: scanner bus; master drives en/load/digits_in, slave returns hex_out/digit_sel/frame_done
interface seg7_scan_mux_if import seg7_scan_mux_pkg::*; #(parameter int NUM_DIGITS = DEF_NUM_DIGITS);
  logic en;
  logic load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [3:0] hex_out;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic frame_done;
  modport master(output en, load, digits_in, input hex_out, digit_sel, frame_done);
  modport slave(input en, load, digits_in, output hex_out, digit_sel, frame_done);
endinterface

// File: rtl/seg7_scan_mux_scan_tick_gen.sv
// scan_tick_gen: prescaler counting 0..TICK_DIV-1 while en_i, tick_o high on the last count (ports clk, rst, en_i, tick_o)
module scan_tick_gen import seg7_scan_mux_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && cnt_q == CW'(TICK_DIV - 1);
  always_comb cnt_d = tick_o ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: tear-free multiplexed 7-seg digit scanner (ports clk, rst, bus: en/load/digits_in in, hex_out/digit_sel/frame_done out)
module seg7_scan_mux import seg7_scan_mux_pkg::*; #(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic clk,
  input logic rst,
  seg7_scan_mux_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  logic tick, bnd;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] active_q, active_d, pending_q, pending_d;
  logic pv_q, pv_d;
  logic [MAX_DIGITS-1:0] blank_v;
  logic [3:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic fd_q;
  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .en_i(bus.en),
    .tick_o(tick)
  );
  always_comb begin
    bnd = tick && idx_q == IW'(NUM_DIGITS - 1);
    idx_d = bnd ? '0 : tick ? idx_q + IW'(1) : idx_q;
    active_d = (bnd && pv_q) ? pending_q : active_q;
    pending_d = bus.load ? bus.digits_in : pending_q;
    pv_d = bus.load | (pv_q & ~bnd);
    blank_v = BLANK_LEADING ? lead_blank_mask(MAX_BITS'(active_d), NUM_DIGITS) : '0;
    sel_d = bus.en ? NUM_DIGITS'(onehot(3'(idx_d))) : '0;
    hex_d = (!bus.en || blank_v[idx_d]) ? BLANK_CODE : active_d[4*idx_d +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      active_q <= '0;
      pending_q <= '0;
      pv_q <= 1'b0;
      hex_q <= BLANK_CODE;
      sel_q <= '0;
      fd_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      active_q <= active_d;
      pending_q <= pending_d;
      pv_q <= pv_d;
      hex_q <= hex_d;
      sel_q <= sel_d;
      fd_q <= bnd;
    end
  end
  assign bus.hex_out = hex_q;
  assign bus.digit_sel = sel_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: table, directed and random checks of seg7_scan_mux with and without leading-zero blanking
module tb_seg7_scan_mux;
  localparam int ND = 4;
  localparam int TD = 4;
  typedef struct {
    logic [15:0] d;
    logic [15:0] x1;
    logic [15:0] x0;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_r = 1'b0;
  logic load_r = 1'b0;
  logic [15:0] din_r = '0;
  always #5 clk = ~clk;
  seg7_scan_mux_if #(.NUM_DIGITS(ND)) b1 ();
  seg7_scan_mux_if #(.NUM_DIGITS(ND)) b0 ();
  assign b1.en = en_r;
  assign b1.load = load_r;
  assign b1.digits_in = din_r;
  assign b0.en = en_r;
  assign b0.load = load_r;
  assign b0.digits_in = din_r;
  seg7_scan_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_LEADING(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  seg7_scan_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_LEADING(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  int vectors = 0;
  int miscompares = 0;
  int m_cnt = 0, m_idx = 0, m_pv = 0;
  logic [15:0] m_act = '0, m_pend = '0;
  int e_sel = 0, e_h1 = 15, e_h0 = 15, e_fd = 0;
  logic [15:0] cap1 = '0, cap0 = '0;
  vec_t tbl[5];
  task automatic chk(input string n, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int shown(input int i, input bit bl);
    int msd = 0;
    for (int j = 0; j < ND; j++) if (m_act[4*j +: 4] != 4'h0) msd = j;
    if (bl && i > msd) return 15;
    return int'(m_act[4*i +: 4]);
  endfunction
  task automatic model();
    bit tick, bnd;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pv = 0; m_act = '0; m_pend = '0;
      e_sel = 0; e_h1 = 15; e_h0 = 15; e_fd = 0;
    end else begin
      tick = en_r && m_cnt == TD - 1;
      bnd = tick && m_idx == ND - 1;
      if (en_r) m_cnt = (m_cnt + 1) % TD;
      if (tick) m_idx = (m_idx + 1) % ND;
      if (bnd && m_pv != 0) begin m_act = m_pend; m_pv = 0; end
      if (load_r) begin m_pend = din_r; m_pv = 1; end
      e_fd = int'(bnd);
      e_sel = en_r ? (1 << m_idx) : 0;
      e_h1 = en_r ? shown(m_idx, 1'b1) : 15;
      e_h0 = en_r ? shown(m_idx, 1'b0) : 15;
    end
  endtask
  task automatic cyc(input logic e, input logic l, input logic [15:0] d, input logic r = 1'b0);
    en_r = e; load_r = l; din_r = d; rst = r;
    @(posedge clk);
    model();
    @(negedge clk);
    chk("sel_blank", b1.digit_sel, e_sel);
    chk("hex_blank", b1.hex_out, e_h1);
    chk("fd_blank", b1.frame_done, e_fd);
    chk("sel_noblank", b0.digit_sel, e_sel);
    chk("hex_noblank", b0.hex_out, e_h0);
    chk("fd_noblank", b0.frame_done, e_fd);
    for (int i = 0; i < ND; i++) if (b1.digit_sel[i]) cap1[4*i +: 4] = b1.hex_out;
    for (int i = 0; i < ND; i++) if (b0.digit_sel[i]) cap0[4*i +: 4] = b0.hex_out;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0);
  endtask
  task automatic align();
    int k = 0;
    while (!(m_cnt == TD - 1 && m_idx == ND - 1) && k < 64) begin cyc(1'b1, 1'b0, 16'h0); k++; end
    if (k >= 64) begin
      vectors++; miscompares++;
      $display("FAIL align_timeout: got %0d cycles expected < 64", k);
    end
  endtask
  task automatic frame(input string n, input logic [15:0] x1, input logic [15:0] x0);
    run(15);
    chk({n, "_blank"}, cap1, x1);
    chk({n, "_noblank"}, cap0, x0);
  endtask
  initial begin
    int last, np;
    logic [15:0] d;
    tbl[0] = '{16'h0050, 16'hFF50, 16'h0050};
    tbl[1] = '{16'h0000, 16'hFFF0, 16'h0000};
    tbl[2] = '{16'h0A00, 16'hFA00, 16'h0A00};
    tbl[3] = '{16'h0007, 16'hFFF7, 16'h0007};
    tbl[4] = '{16'h1234, 16'h1234, 16'h1234};
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    chk("rst_sel", b1.digit_sel, 0);
    chk("rst_hex", b1.hex_out, 15);
    chk("rst_fd", b1.frame_done, 0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("first_sel", b1.digit_sel, 1);
    chk("first_hex", b1.hex_out, 0);
    cyc(1'b1, 1'b1, 16'h1234);
    align();
    cyc(1'b1, 1'b0, 16'h0);
    frame("scan1234", 16'h1234, 16'h1234);
    last = -1; np = 0;
    for (int i = 0; i < 48; i++) begin
      cyc(1'b1, 1'b0, 16'h0);
      if (b1.frame_done) begin
        if (last >= 0) chk("fd_gap", i - last, 16);
        last = i; np++;
      end
    end
    chk("fd_count", np, 3);
    for (int t = 0; t < 5; t++) begin
      cyc(1'b1, 1'b1, tbl[t].d);
      run(48);
      chk("tbl_blank", cap1, tbl[t].x1);
      chk("tbl_noblank", cap0, tbl[t].x0);
    end
    align();
    cyc(1'b1, 1'b1, 16'h5678);
    frame("bnd_nopend", 16'h1234, 16'h1234);
    cyc(1'b1, 1'b0, 16'h0);
    frame("bnd_nopend_next", 16'h5678, 16'h5678);
    cyc(1'b1, 1'b1, 16'h9ABC);
    align();
    cyc(1'b1, 1'b1, 16'h4321);
    frame("bnd_pend", 16'h9ABC, 16'h9ABC);
    cyc(1'b1, 1'b0, 16'h0);
    frame("bnd_pend_next", 16'h4321, 16'h4321);
    align();
    cyc(1'b1, 1'b0, 16'h0);
    run(2);
    cyc(1'b1, 1'b1, 16'h1111);
    run(1);
    cyc(1'b1, 1'b1, 16'h2222);
    run(10);
    chk("lww_tear", cap1, 16'h4321);
    cyc(1'b1, 1'b0, 16'h0);
    frame("lww_next", 16'h2222, 16'h2222);
    align();
    run(2);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      chk("enlow_sel", b1.digit_sel, 0);
      chk("enlow_hex", b1.hex_out, 15);
      chk("enlow_fd", b1.frame_done, 0);
    end
    cyc(1'b1, 1'b0, 16'h0);
    chk("resume_sel0", b1.digit_sel, 1);
    cyc(1'b1, 1'b0, 16'h0);
    chk("resume_sel1", b1.digit_sel, 1);
    cyc(1'b1, 1'b0, 16'h0);
    chk("resume_sel2", b1.digit_sel, 2);
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    chk("midrst_sel", b1.digit_sel, 0);
    chk("midrst_hex", b1.hex_out, 15);
    chk("midrst_fd", b1.frame_done, 0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("postrst_sel", b1.digit_sel, 1);
    chk("postrst_hex", b1.hex_out, 0);
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < ND; j++) d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 19) == 0, d, $urandom_range(0, 199) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
